// File: rtl/maze_mem_arbiter_pkg.sv
// Shared types for the maze memory arbiter: address width, FSM state and port select.
package mazePkg;

  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE
  } arbState_t;

  typedef enum logic {
    PORT_A,
    PORT_B
  } portSel_t;

endpackage

// File: rtl/maze_mem_arbiter_if.sv
// Requester and memory signals of the maze memory arbiter, grouped as one bus.
// slave = arbiter side, master = requesters plus the memory (bench side).
interface maze_mem_arbiter_if #(
  parameter int ADDR_W = mazePkg::ADDR_W
) ();

  // Handshake: xReq is a level held with xWr/xLoc/xDin stable until the
  // one-cycle xGnt pulse; reads return xDout with a one-cycle xValid pulse.
  logic              aReq;
  logic              aWr;
  logic [ADDR_W-1:0] aLoc;
  logic              aDin;
  logic              aGnt;
  logic              aDout;
  logic              aValid;

  logic              bReq;
  logic              bWr;
  logic [ADDR_W-1:0] bLoc;
  logic              bDin;
  logic              bGnt;
  logic              bDout;
  logic              bValid;

  logic [ADDR_W-1:0] memLoc;
  logic              memDin;
  logic              memRd;
  logic              memWr;
  logic              memDout;

  modport slave (
    input  aReq, aWr, aLoc, aDin,
    output aGnt, aDout, aValid,
    input  bReq, bWr, bLoc, bDin,
    output bGnt, bDout, bValid,
    output memLoc, memDin, memRd, memWr,
    input  memDout
  );

  modport master (
    output aReq, aWr, aLoc, aDin,
    input  aGnt, aDout, aValid,
    output bReq, bWr, bLoc, bDin,
    input  bGnt, bDout, bValid,
    input  memLoc, memDin, memRd, memWr,
    output memDout
  );

endinterface

// File: rtl/maze_mem_arbiter_rr_picker2.sv
// Combinational two-way round-robin winner: on a tie the port that was not
// granted last wins; a lone requester always wins.
module rrPicker2 (
  input  logic             i_aReq,
  input  logic             i_bReq,
  input  mazePkg::portSel_t i_last,
  output mazePkg::portSel_t o_pick
);
  import mazePkg::*;

  always_comb begin
    o_pick = PORT_A;
    if (i_aReq && i_bReq) begin
      o_pick = (i_last == PORT_A) ? PORT_B : PORT_A;
    end else if (i_bReq) begin
      o_pick = PORT_B;
    end
  end

endmodule

// File: rtl/maze_mem_arbiter.sv
// Two-port arbiter/sequencer for the single-port 16x16 maze bit memory.
// Define MAZE_ARB_FIXED_PRIO_EN for fixed A-over-B priority instead of round-robin.
module maze_mem_arbiter #(
  parameter int ADDR_W = mazePkg::ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  maze_mem_arbiter_if.slave  bus,
  output mazePkg::arbState_t o_state
);
  import mazePkg::*;

  arbState_t         r_state;
  portSel_t          r_owner;
  logic              r_aGnt;
  logic              r_bGnt;
  logic              r_aValid;
  logic              r_bValid;
  logic              r_aDout;
  logic              r_bDout;
  logic [ADDR_W-1:0] r_memLoc;
  logic              r_memDin;
  logic              r_memRd;
  logic              r_memWr;

  logic              w_anyReq;
  portSel_t          w_pick;

  assign w_anyReq = bus.aReq || bus.bReq;

`ifdef MAZE_ARB_FIXED_PRIO_EN
  assign w_pick = bus.aReq ? PORT_A : PORT_B;
`else
  portSel_t r_last;

  rrPicker2 u_picker (
    .i_aReq (bus.aReq),
    .i_bReq (bus.bReq),
    .i_last (r_last),
    .o_pick (w_pick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last <= PORT_B;
    end else if (r_state == IDLE && w_anyReq) begin
      r_last <= w_pick;
    end
  end
`endif

  // Strobes live only in ISSUE; the memory performs the access at its exit edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_owner  <= PORT_A;
      r_aGnt   <= 1'b0;
      r_bGnt   <= 1'b0;
      r_aValid <= 1'b0;
      r_bValid <= 1'b0;
      r_aDout  <= 1'b0;
      r_bDout  <= 1'b0;
      r_memLoc <= '0;
      r_memDin <= 1'b0;
      r_memRd  <= 1'b0;
      r_memWr  <= 1'b0;
    end else begin
      r_aGnt   <= 1'b0;
      r_bGnt   <= 1'b0;
      r_aValid <= 1'b0;
      r_bValid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            if (w_pick == PORT_A) begin
              r_memLoc <= bus.aLoc;
              r_memDin <= bus.aDin;
              r_memWr  <= bus.aWr;
              r_memRd  <= !bus.aWr;
              r_aGnt   <= 1'b1;
            end else begin
              r_memLoc <= bus.bLoc;
              r_memDin <= bus.bDin;
              r_memWr  <= bus.bWr;
              r_memRd  <= !bus.bWr;
              r_bGnt   <= 1'b1;
            end
            r_owner <= w_pick;
            r_state <= ISSUE;
          end else begin
            r_memRd <= 1'b0;
            r_memWr <= 1'b0;
          end
        end
        ISSUE: begin
          r_memRd <= 1'b0;
          r_memWr <= 1'b0;
          r_state <= r_memRd ? CAPTURE : IDLE;
        end
        CAPTURE: begin
          if (r_owner == PORT_A) begin
            r_aDout  <= bus.memDout;
            r_aValid <= 1'b1;
          end else begin
            r_bDout  <= bus.memDout;
            r_bValid <= 1'b1;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.aGnt   = r_aGnt;
  assign bus.bGnt   = r_bGnt;
  assign bus.aValid = r_aValid;
  assign bus.bValid = r_bValid;
  assign bus.aDout  = r_aDout;
  assign bus.bDout  = r_bDout;
  assign bus.memLoc = r_memLoc;
  assign bus.memDin = r_memDin;
  assign bus.memRd  = r_memRd;
  assign bus.memWr  = r_memWr;
  assign o_state    = r_state;

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Directed bench for maze_mem_arbiter with a behavioral maze memory.
// Follows MAZE_ARB_FIXED_PRIO_EN for the expected grant order.
module tb_maze_mem_arbiter;
  import mazePkg::*;

  logic      clk = 1'b0;
  logic      rst = 1'b0;
  arbState_t dbg_state;
  int        errors = 0;
  int        checks = 0;

  maze_mem_arbiter_if #(.ADDR_W(8)) bus ();

  maze_mem_arbiter #(.ADDR_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Map image: cell {y,x} is a wall when x+y is odd (so 21->1, 22->0, 01->1, 00->0, 3F->0).
  function automatic logic map_bit(input int idx);
    int sx;
    int sy;
    sx = idx % 16;
    sy = idx / 16;
    return logic'((sx + sy) % 2);
  endfunction

  logic mem     [256];
  logic ref_mem [256];

  // Behavioral single-port memory with no reset; data returns the cycle after memRd.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = map_bit(i);
    bus.memDout = 1'b0;
    forever begin
      @(posedge clk);
      if (bus.memWr) mem[bus.memLoc] <= bus.memDin;
      if (bus.memRd) bus.memDout <= mem[bus.memLoc];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_aGnt"},   32'(bus.aGnt),   32'd0);
    chk({tag, "_bGnt"},   32'(bus.bGnt),   32'd0);
    chk({tag, "_aValid"}, 32'(bus.aValid), 32'd0);
    chk({tag, "_bValid"}, 32'(bus.bValid), 32'd0);
    chk({tag, "_memRd"},  32'(bus.memRd),  32'd0);
    chk({tag, "_memWr"},  32'(bus.memWr),  32'd0);
    chk({tag, "_state"},  32'(dbg_state),  32'(IDLE));
  endtask

  int gport [8];
  int gcyc  [8];
  int ng;
  int cyc;
  int na_val;
  int nb_val;
  int bad_cells;
  int exp_port [4];

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = map_bit(i);
    bus.aReq = 0; bus.aWr = 0; bus.aLoc = '0; bus.aDin = 0;
    bus.bReq = 0; bus.bWr = 0; bus.bLoc = '0; bus.bDin = 0;

    // Reset held for 3 cycles: every output is 0.
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("rst");
    chk("rst_aDout",  32'(bus.aDout),  32'd0);
    chk("rst_bDout",  32'(bus.bDout),  32'd0);
    chk("rst_memLoc", 32'(bus.memLoc), 32'd0);
    chk("rst_memDin", 32'(bus.memDin), 32'd0);
    rst = 1'b1;

    // Single A read of 8'h21 (map bit 1).
    @(negedge clk);
    bus.aLoc = 8'h21; bus.aWr = 0; bus.aDin = 0; bus.aReq = 1;
    @(negedge clk);
    chk("rdA_aGnt",   32'(bus.aGnt),   32'd1);
    chk("rdA_bGnt",   32'(bus.bGnt),   32'd0);
    chk("rdA_memRd",  32'(bus.memRd),  32'd1);
    chk("rdA_memWr",  32'(bus.memWr),  32'd0);
    chk("rdA_memLoc", 32'(bus.memLoc), 32'h21);
    bus.aReq = 0;
    @(negedge clk);
    chk("rdA_memRd_off", 32'(bus.memRd), 32'd0);
    chk("rdA_aGnt_off",  32'(bus.aGnt),  32'd0);
    chk("rdA_early_val", 32'(bus.aValid), 32'd0);
    @(negedge clk);
    chk("rdA_aValid", 32'(bus.aValid), 32'd1);
    chk("rdA_aDout",  32'(bus.aDout),  32'd1);
    chk("rdA_bValid", 32'(bus.bValid), 32'd0);
    @(negedge clk);
    chk("rdA_pulse",  32'(bus.aValid), 32'd0);
    chk("rdA_hold",   32'(bus.aDout),  32'd1);

    // B writes 1 to 8'h3F, then A reads it back.
    bus.bLoc = 8'h3F; bus.bDin = 1; bus.bWr = 1; bus.bReq = 1;
    @(negedge clk);
    chk("wrB_bGnt",   32'(bus.bGnt),   32'd1);
    chk("wrB_memWr",  32'(bus.memWr),  32'd1);
    chk("wrB_memRd",  32'(bus.memRd),  32'd0);
    chk("wrB_memLoc", 32'(bus.memLoc), 32'h3F);
    chk("wrB_memDin", 32'(bus.memDin), 32'd1);
    bus.bReq = 0;
    ref_mem[8'h3F] = 1'b1;
    @(negedge clk);
    chk_quiet("wrB_done");
    bus.aLoc = 8'h3F; bus.aWr = 0; bus.aReq = 1;
    @(negedge clk);
    chk("rd3F_aGnt",   32'(bus.aGnt),   32'd1);
    chk("rd3F_memLoc", 32'(bus.memLoc), 32'h3F);
    bus.aReq = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rd3F_aValid", 32'(bus.aValid), 32'd1);
    chk("rd3F_aDout",  32'(bus.aDout),  32'd1);
    chk("rd3F_bValid", 32'(bus.bValid), 32'd0);

    // Fresh reset, then both ports hold reads for 4 transactions.
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
`ifdef MAZE_ARB_FIXED_PRIO_EN
    exp_port = '{0, 0, 0, 0};
`else
    exp_port = '{0, 1, 0, 1};
`endif
    bus.aLoc = 8'h21; bus.aWr = 0; bus.bLoc = 8'h22; bus.bWr = 0;
    bus.aReq = 1; bus.bReq = 1;
    ng = 0; cyc = 0; na_val = 0; nb_val = 0;
    while (cyc < 60 && (ng < 4 || cyc < gcyc[3] + 4)) begin
      @(negedge clk);
      cyc++;
      chk("tie_gnt_onehot", 32'(bus.aGnt && bus.bGnt), 32'd0);
      if (bus.aGnt && ng < 8) begin gport[ng] = 0; gcyc[ng] = cyc; ng++; end
      if (bus.bGnt && ng < 8) begin gport[ng] = 1; gcyc[ng] = cyc; ng++; end
      if (bus.aValid) begin chk("tie_aDout", 32'(bus.aDout), 32'd1); na_val++; end
      if (bus.bValid) begin chk("tie_bDout", 32'(bus.bDout), 32'd0); nb_val++; end
      if (ng >= 4) begin bus.aReq = 0; bus.bReq = 0; end
    end
    chk("tie_ngrants", 32'(ng), 32'd4);
    for (int i = 0; i < 4 && i < ng; i++) begin
      chk($sformatf("tie_port%0d", i), 32'(gport[i]), 32'(exp_port[i]));
      if (i > 0) chk($sformatf("tie_gap%0d", i), 32'(gcyc[i] - gcyc[i-1]), 32'd3);
    end
`ifdef MAZE_ARB_FIXED_PRIO_EN
    chk("tie_na_val", 32'(na_val), 32'd4);
    chk("tie_nb_val", 32'(nb_val), 32'd0);
`else
    chk("tie_na_val", 32'(na_val), 32'd2);
    chk("tie_nb_val", 32'(nb_val), 32'd2);
`endif
    bus.aReq = 0; bus.bReq = 0;
    @(negedge clk);

    // Reset asserted during CAPTURE of an A read.
    bus.aLoc = 8'h21; bus.aWr = 0; bus.aReq = 1;
    @(negedge clk);
    chk("rstcap_aGnt", 32'(bus.aGnt), 32'd1);
    bus.aReq = 0;
    @(negedge clk);
    chk("rstcap_state", 32'(dbg_state), 32'(CAPTURE));
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("rstcap");
    rst = 1'b1;
    @(negedge clk);
    chk("rstcap_after", 32'(bus.aValid), 32'd0);

    // A write of 8'h00 and B read of 8'h01 requested together; last is B after reset.
    bus.aWr = 1; bus.aLoc = 8'h00; bus.aDin = 1;
    bus.bWr = 0; bus.bLoc = 8'h01;
    bus.aReq = 1; bus.bReq = 1;
    ng = 0; cyc = 0; nb_val = 0;
    while (cyc < 30 && nb_val == 0) begin
      @(negedge clk);
      cyc++;
      if (bus.aGnt && ng < 8) begin gport[ng] = 0; gcyc[ng] = cyc; ng++; bus.aReq = 0; end
      if (bus.bGnt && ng < 8) begin gport[ng] = 1; gcyc[ng] = cyc; ng++; bus.bReq = 0; end
      if (bus.bValid) begin chk("mix_bDout", 32'(bus.bDout), 32'd1); nb_val++; end
      chk("mix_no_aValid", 32'(bus.aValid), 32'd0);
    end
    bus.aReq = 0; bus.bReq = 0;
    ref_mem[8'h00] = 1'b1;
    chk("mix_ngrants", 32'(ng), 32'd2);
    chk("mix_bValid_seen", 32'(nb_val), 32'd1);
    if (ng == 2) begin
      chk("mix_first",  32'(gport[0]), 32'd0);
      chk("mix_second", 32'(gport[1]), 32'd1);
      chk("mix_gap",    32'(gcyc[1] - gcyc[0]), 32'd2);
    end
    @(negedge clk);

    bad_cells = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad_cells++;
    chk("mem_contents", 32'(bad_cells), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
